// File: rtl/count_trace_pkg.sv
// Shared definitions for the counter trace buffer: state encoding and default widths.
package count_trace_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  localparam int unsigned DEFAULT_DATA_W = 4;

endpackage

// File: rtl/trace_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module trace_mem #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are qualified by the level counter upstream, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/count_trace_buffer.sv
// Trigger-armed capture of DEPTH consecutive counter samples, drained over a valid/ready port.
module count_trace_buffer
  import count_trace_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [LW-1:0]     level,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              trig_hit, wr_en, rd_fire, last_rd;

  assign trig_hit = (state_q == ST_ARMED) && sample_valid && (sample_in == trig_value);
  assign wr_en    = trig_hit || ((state_q == ST_CAPTURE) && sample_valid);
  assign rd_fire  = (state_q == ST_DRAIN) && (level_q != '0) && rd_ready;
  assign last_rd  = rd_fire && (level_q == LW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every FSM event
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arm) state_d = ST_ARMED;
      ST_ARMED:   if (trig_hit) state_d = ST_CAPTURE;
      ST_CAPTURE: if (wr_en && (level_q == LW'(DEPTH - 1))) state_d = ST_DRAIN;
      ST_DRAIN:   if (last_rd) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  // Pointers and level; writes and reads live in disjoint states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      level_q  <= level_q + LW'(1);
    end else if (rd_fire) begin
      rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_q - LW'(1);
    end
  end

  trace_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && !abort),
    .waddr (wr_ptr_q),
    .wdata (sample_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Output logic
  always_comb begin
    rd_valid = (state_q == ST_DRAIN) && (level_q != '0);
    rd_data  = (level_q != '0) ? mem_rdata : '0;
    level    = level_q;
    busy     = (state_q != ST_IDLE);
    done     = last_rd && !abort;
  end

endmodule

// File: tb/tb_count_trace_buffer.sv
// Self-checking bench for count_trace_buffer: table-driven runs plus abort and reset sequences.
module tb_count_trace_buffer;

  logic       clk = 1'b0;
  logic       rst, arm, abort, sample_valid, rd_ready;
  logic [3:0] sample_in, trig_value;
  logic       rd_valid, busy, done;
  logic [3:0] rd_data;
  logic [3:0] level;

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  count_trace_buffer #(
    .DATA_W (4),
    .DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .trig_value   (trig_value),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .level        (level),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [3:0] trig;
    bit         stall;
    int         gap_after;
    int         gaps;
    logic [3:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Arms, then feeds an incrementing counter until n_wr samples have been stored.
  task automatic capture(input logic [3:0] trig, input int n_wr, input int gap_after,
                         input int gaps, input bit arm_mid);
    logic [3:0] cnt;
    int wr, gap_left, cyc;
    cnt = trig - 4'd2;
    wr = 0;
    gap_left = gaps;
    cyc = 0;
    trig_value = trig;
    arm = 1'b1;
    sample_valid = 1'b1;
    sample_in = cnt;
    next_cycle();
    arm = 1'b0;
    cnt = cnt + 4'd1;
    while (wr < n_wr && cyc < 64) begin
      check("cap_busy", int'(busy), 1);
      check("cap_rd_valid", int'(rd_valid), 0);
      check("cap_level", int'(level), wr);
      if (wr == gap_after && gap_left > 0) begin
        sample_valid = 1'b0;
        gap_left--;
      end else begin
        sample_valid = 1'b1;
      end
      sample_in = cnt;
      arm = arm_mid && (wr == 4);
      if (sample_valid && (wr > 0 || cnt == trig)) begin
        exp_q.push_back(cnt);
        wr++;
      end
      next_cycle();
      if (sample_valid) cnt = cnt + 4'd1;
      cyc++;
    end
    if (cyc >= 64) check("capture_timeout", 0, 1);
    sample_valid = 1'b0;
    arm = 1'b0;
    #1;
  endtask

  task automatic drain(input bit stall, input int n_rd, output logic [3:0] last);
    int rd, cyc;
    logic [3:0] held, exp;
    bit was_stall;
    rd = 0;
    cyc = 0;
    was_stall = 1'b0;
    held = '0;
    last = '0;
    while (rd < n_rd && cyc < 64) begin
      rd_ready = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      check("drain_rd_valid", int'(rd_valid), 1);
      if (was_stall) check("stall_hold", int'(rd_data), int'(held));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("rd_data", int'(rd_data), int'(exp));
          check("done_pulse", int'(done), int'(exp_q.size() == 0));
          last = rd_data;
        end
        rd++;
      end else begin
        check("done_idle", int'(done), 0);
      end
      held = rd_data;
      was_stall = rd_valid && !rd_ready;
      next_cycle();
      cyc++;
    end
    if (cyc >= 64) check("drain_timeout", 0, 1);
    rd_ready = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] last;
    vecs[0] = '{trig: 4'd3,  stall: 1'b0, gap_after: 99, gaps: 0, exp_last: 4'd10};
    vecs[1] = '{trig: 4'd12, stall: 1'b0, gap_after: 99, gaps: 0, exp_last: 4'd3};
    vecs[2] = '{trig: 4'd3,  stall: 1'b1, gap_after: 99, gaps: 0, exp_last: 4'd10};
    vecs[3] = '{trig: 4'd7,  stall: 1'b0, gap_after: 3,  gaps: 2, exp_last: 4'd14};

    rst = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    trig_value = '0;
    rd_ready = 1'b0;
    @(negedge clk);
    #1;
    idle_check("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 4; i++) begin
      exp_q.delete();
      capture(vecs[i].trig, 8, vecs[i].gap_after, vecs[i].gaps, 1'b0);
      check("drain_entry_rd_valid", int'(rd_valid), 1);
      check("peak_level", int'(level), 8);
      drain(vecs[i].stall, 8, last);
      check("last_value", int'(last), int'(vecs[i].exp_last));
      idle_check("post_drain");
    end

    // Abort after five captures: flushed, no done pulse
    exp_q.delete();
    capture(4'd9, 5, 99, 0, 1'b0);
    check("pre_abort_level", int'(level), 5);
    abort = 1'b1;
    #1;
    check("abort_done", int'(done), 0);
    next_cycle();
    abort = 1'b0;
    #1;
    idle_check("post_abort");
    exp_q.delete();
    capture(4'd0, 8, 99, 0, 1'b0);
    check("trig0_level", int'(level), 8);
    drain(1'b0, 8, last);
    check("trig0_last", int'(last), 7);
    idle_check("trig0_end");

    // Arm during capture is ignored; async reset mid-drain clears everything
    exp_q.delete();
    capture(4'd5, 8, 99, 0, 1'b1);
    check("arm_mid_level", int'(level), 8);
    drain(1'b0, 4, last);
    check("partial_last", int'(last), 8);
    check("partial_level", int'(level), 4);
    check("partial_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    idle_check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    idle_check("after_rst");
    exp_q.delete();
    capture(4'd3, 8, 99, 0, 1'b0);
    drain(1'b0, 8, last);
    check("recover_last", int'(last), 10);
    idle_check("recover_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
